// File: rtl/cactus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cactus_pkg
// Purpose  : Shared definitions for the cactus game blocks: collision-check
//            FSM state encoding, screen width and default sprite widths. The
//            cactus mover and the renderer use the same constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cactus_pkg;

  // First x coordinate that is off the right edge of the screen.
  localparam int SCREEN_W = 320;
  // Default sprite widths in pixels.
  localparam int CACTUS_W = 10;
  localparam int DINO_W   = 20;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_CHK1   = 3'd2,
    ST_CHK2   = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

endpackage : cactus_pkg
`default_nettype wire

// File: rtl/box_overlap.sv
`default_nettype none
// ============================================================================
// Module   : box_overlap
// Purpose  : Combinational test of one cactus against the dino: on-screen,
//            horizontal overlap and vertical overlap.
// Ports    : i_cx        cactus left x (9 bit)
//            i_height    cactus height above ground (9 bit)
//            i_dino_x    dino left x (9 bit)
//            i_dino_alt  dino feet altitude above ground (9 bit)
//            o_on_screen cactus left edge is left of SCREEN_W
//            o_h_overlap horizontal spans intersect
//            o_v_overlap dino feet are below the cactus top
// Revision : 1.0 - initial release
// ============================================================================
module box_overlap
  import cactus_pkg::*;
#(
  parameter int CACTUS_W = cactus_pkg::CACTUS_W,
  parameter int DINO_W   = cactus_pkg::DINO_W,
  parameter int SCREEN_W = cactus_pkg::SCREEN_W
) (
  input  logic [8:0] i_cx,
  input  logic [8:0] i_height,
  input  logic [8:0] i_dino_x,
  input  logic [8:0] i_dino_alt,
  output logic       o_on_screen,
  output logic       o_h_overlap,
  output logic       o_v_overlap
);

  // Right edges are formed at 10 bits so a sprite near x=511 cannot wrap
  // back to a small value and fake an overlap.
  logic [9:0] w_cx_ext;
  logic [9:0] w_dino_ext;
  logic [9:0] w_cactus_right;
  logic [9:0] w_dino_right;

  assign w_cx_ext       = {1'b0, i_cx};
  assign w_dino_ext     = {1'b0, i_dino_x};
  assign w_cactus_right = w_cx_ext + 10'(CACTUS_W);
  assign w_dino_right   = w_dino_ext + 10'(DINO_W);

  assign o_on_screen = (w_cx_ext < 10'(SCREEN_W));
  assign o_h_overlap = (w_cx_ext < w_dino_right) && (w_dino_ext < w_cactus_right);
  assign o_v_overlap = (i_dino_alt < i_height);

endmodule : box_overlap
`default_nettype wire

// File: rtl/cactus_collide.sv
`default_nettype none
// ============================================================================
// Module   : cactus_collide
// Purpose  : Per-frame collision check of the dino against two cacti, with a
//            life counter and sticky game-over flag. Cactus2 sits at
//            (pixel + x_dist) mod 512. One shared box_overlap is time-shared
//            between the two cacti (CHK1, CHK2).
// Config   : `define CACTUS_COLLIDE_GRACE_EN adds a post-hit immunity counter
//            of GRACE_FRAMES completed frames.
// Ports    : clk, rst (sync, active-high)
//            enable, frame_tick, clear                 control inputs
//            pixel, x_dist, height1, height2,
//            dino_x, dino_alt                          9-bit geometry inputs
//            busy, done, hit                           status / pulses
//            lives_left[1:0], game_over                game state
// Timing   : tick accepted in cycle N -> busy N+1..N+4, done and hit in N+4,
//            lives_left / game_over already reflect the hit in N+4.
// Revision : 1.0 - initial release
// ============================================================================
module cactus_collide
  import cactus_pkg::*;
#(
  parameter int CACTUS_W     = cactus_pkg::CACTUS_W,
  parameter int DINO_W       = cactus_pkg::DINO_W,
  parameter int SCREEN_W     = cactus_pkg::SCREEN_W,
  parameter int LIVES        = 3,
  parameter int GRACE_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       clear,
  input  logic [8:0] pixel,
  input  logic [8:0] x_dist,
  input  logic [8:0] height1,
  input  logic [8:0] height2,
  input  logic [8:0] dino_x,
  input  logic [8:0] dino_alt,
  output logic       busy,
  output logic       done,
  output logic       hit,
  output logic [1:0] lives_left,
  output logic       game_over
);

  state_t     r_state;
  state_t     w_state_next;

  // Snapshot of the frame's geometry, taken in SAMPLE.
  logic [8:0] r_cx1;
  logic [8:0] r_cx2;
  logic [8:0] r_h1;
  logic [8:0] r_h2;
  logic [8:0] r_dino_x;
  logic [8:0] r_dino_alt;

  logic       r_c1_coll;    // cactus1 result from CHK1
  logic       r_count;      // frame collision that will be counted in REPORT
  logic [1:0] r_lives;
  logic       r_game_over;

  logic [8:0] w_cx;
  logic [8:0] w_height;
  logic       w_on_screen;
  logic       w_h_overlap;
  logic       w_v_overlap;
  logic       w_cactus_coll;
  logic       w_grace_ok;
  logic       w_done;
  logic       w_hit;
  logic [1:0] w_lives;
  logic       w_game_over;

  // --------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (frame_tick && enable && !r_game_over) begin
          w_state_next = ST_SAMPLE;
        end
      end
      ST_SAMPLE: w_state_next = ST_CHK1;
      ST_CHK1:   w_state_next = ST_CHK2;
      ST_CHK2:   w_state_next = ST_REPORT;
      ST_REPORT: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shared overlap test, muxed between the two cacti
  // --------------------------------------------------------------------------
  assign w_cx     = (r_state == ST_CHK2) ? r_cx2 : r_cx1;
  assign w_height = (r_state == ST_CHK2) ? r_h2  : r_h1;

  box_overlap #(
    .CACTUS_W (CACTUS_W),
    .DINO_W   (DINO_W),
    .SCREEN_W (SCREEN_W)
  ) u_box_overlap (
    .i_cx        (w_cx),
    .i_height    (w_height),
    .i_dino_x    (r_dino_x),
    .i_dino_alt  (r_dino_alt),
    .o_on_screen (w_on_screen),
    .o_h_overlap (w_h_overlap),
    .o_v_overlap (w_v_overlap)
  );

  assign w_cactus_coll = w_on_screen && w_h_overlap && w_v_overlap;

  // --------------------------------------------------------------------------
  // Optional post-hit immunity
  // --------------------------------------------------------------------------
`ifdef CACTUS_COLLIDE_GRACE_EN
  localparam int GW = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);

  logic [GW-1:0] r_grace;

  assign w_grace_ok = (r_grace == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grace <= '0;
    end else if (!clear && (r_state == ST_REPORT)) begin
      if (w_hit) begin
        r_grace <= GW'(GRACE_FRAMES);
      end else if (r_grace != '0) begin
        r_grace <= r_grace - GW'(1);
      end
    end
  end
`else
  logic w_unused_grace;
  assign w_unused_grace = (GRACE_FRAMES != 0);
  assign w_grace_ok     = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Outputs. The REPORT cycle shows the post-hit lives / game_over values
  // combinationally; they are committed to the registers at the end of REPORT.
  // --------------------------------------------------------------------------
  assign w_done      = (r_state == ST_REPORT);
  assign w_hit       = w_done && r_count;
  assign w_lives     = r_lives - {1'b0, w_hit};
  assign w_game_over = r_game_over || (w_hit && (r_lives == 2'd1));

  assign busy       = (r_state != ST_IDLE);
  assign done       = w_done;
  assign hit        = w_hit;
  assign lives_left = w_lives;
  assign game_over  = w_game_over;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cx1       <= '0;
      r_cx2       <= '0;
      r_h1        <= '0;
      r_h2        <= '0;
      r_dino_x    <= '0;
      r_dino_alt  <= '0;
      r_c1_coll   <= 1'b0;
      r_count     <= 1'b0;
      r_lives     <= 2'(LIVES);
      r_game_over <= 1'b0;
    end else if (clear) begin
      r_c1_coll   <= 1'b0;
      r_count     <= 1'b0;
      r_lives     <= 2'(LIVES);
      r_game_over <= 1'b0;
    end else begin
      if (r_state == ST_SAMPLE) begin
        r_cx1      <= pixel;
        r_cx2      <= pixel + x_dist;   // 9-bit wrap is intended
        r_h1       <= height1;
        r_h2       <= height2;
        r_dino_x   <= dino_x;
        r_dino_alt <= dino_alt;
      end
      if (r_state == ST_CHK1) begin
        r_c1_coll <= w_cactus_coll;
      end
      if (r_state == ST_CHK2) begin
        // Either cactus colliding counts as a single hit for the frame.
        r_count <= (r_c1_coll || w_cactus_coll) && w_grace_ok && (r_lives != 2'd0);
      end
      if (r_state == ST_REPORT) begin
        r_lives     <= w_lives;
        r_game_over <= w_game_over;
        r_count     <= 1'b0;
      end
    end
  end

endmodule : cactus_collide
`default_nettype wire

// File: tb/tb_cactus_collide.sv
`default_nettype none
// ============================================================================
// Module   : tb_cactus_collide
// Purpose  : Directed self-checking bench for cactus_collide. A reference
//            model computes each frame's expected hit / lives / game_over,
//            pushes it to a scoreboard queue when the tick is driven, and the
//            entry is popped and compared in the done cycle.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cactus_collide;

  localparam int TB_LIVES = 3;
  localparam int TB_GRACE = 2;

  logic       clk = 1'b0;
  logic       rst, enable, frame_tick, clear;
  logic [8:0] pixel, x_dist, height1, height2, dino_x, dino_alt;
  logic       busy, done, hit, game_over;
  logic [1:0] lives_left;

  always #5 clk = ~clk;

  cactus_collide #(
    .CACTUS_W     (10),
    .DINO_W       (20),
    .SCREEN_W     (320),
    .LIVES        (TB_LIVES),
    .GRACE_FRAMES (TB_GRACE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .frame_tick (frame_tick),
    .clear      (clear),
    .pixel      (pixel),
    .x_dist     (x_dist),
    .height1    (height1),
    .height2    (height2),
    .dino_x     (dino_x),
    .dino_alt   (dino_alt),
    .busy       (busy),
    .done       (done),
    .hit        (hit),
    .lives_left (lives_left),
    .game_over  (game_over)
  );

  typedef struct {
    logic       hit;
    logic [1:0] lives;
    logic       go;
  } exp_t;

  exp_t q_exp[$];

  int n_pass  = 0;
  int n_total = 0;

  int m_lives = TB_LIVES;
  int m_go    = 0;
  int m_grace = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sample point: 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cactus_hits(int cx, int h, int dx, int da);
    return (cx < 320) && (cx < dx + 20) && (dx < cx + 10) && (da < h);
  endfunction

  // Reference model for one completed frame, using the current inputs.
  task automatic model_frame();
    exp_t e;
    int   cx2;
    bit   c;
    bit   counted;
    cx2 = (int'(pixel) + int'(x_dist)) % 512;
    c   = cactus_hits(int'(pixel), int'(height1), int'(dino_x), int'(dino_alt)) ||
          cactus_hits(cx2, int'(height2), int'(dino_x), int'(dino_alt));
    counted = c && (m_lives != 0);
`ifdef CACTUS_COLLIDE_GRACE_EN
    counted = counted && (m_grace == 0);
    if (counted)          m_grace = TB_GRACE;
    else if (m_grace > 0) m_grace--;
`endif
    if (counted) begin
      m_lives--;
      if (m_lives == 0) m_go = 1;
    end
    e.hit   = counted;
    e.lives = 2'(m_lives);
    e.go    = m_go[0];
    q_exp.push_back(e);
  endtask

  task automatic set_geom(input int p, input int xd, input int h1, input int h2,
                          input int dx, input int da);
    pixel    = 9'(p);
    x_dist   = 9'(xd);
    height1  = 9'(h1);
    height2  = 9'(h2);
    dino_x   = 9'(dx);
    dino_alt = 9'(da);
  endtask

  // One full frame. With disturb set, the geometry is scrambled and a
  // second tick is driven mid-check; neither may change the outcome.
  task automatic run_frame(input string tag, input bit disturb);
    exp_t       e;
    logic [8:0] sv_p, sv_a;
    model_frame();
    frame_tick = 1'b1;
    step();                                   // cycle N+1
    frame_tick = 1'b0;
    check({tag, " busy@1"}, 32'(busy), 32'd1);
    step();                                   // cycle N+2
    if (disturb) begin
      sv_p = pixel; sv_a = dino_alt;
      pixel = 9'd0; dino_alt = 9'd300; frame_tick = 1'b1;
    end
    step();                                   // cycle N+3
    frame_tick = 1'b0;
    if (disturb) begin
      pixel = sv_p; dino_alt = sv_a;
    end
    check({tag, " done@3"}, 32'(done), 32'd0);
    step();                                   // cycle N+4
    check({tag, " done@4"}, 32'(done), 32'd1);
    if (q_exp.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = q_exp.pop_front();
      check({tag, " hit"},   32'(hit),        32'(e.hit));
      check({tag, " lives"}, 32'(lives_left), 32'(e.lives));
      check({tag, " go"},    32'(game_over),  32'(e.go));
    end
    step();                                   // cycle N+5
    check({tag, " busy@5"}, 32'(busy), 32'd0);
    check({tag, " hit@5"},  32'(hit),  32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; frame_tick = 1'b0; clear = 1'b0;
    set_geom(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
    check("reset busy",  32'(busy),       32'd0);
    check("reset done",  32'(done),       32'd0);
    check("reset hit",   32'(hit),        32'd0);
    check("reset lives", 32'(lives_left), 32'(TB_LIVES));
    check("reset go",    32'(game_over),  32'd0);

    // Cactus1 collision, with mid-check input scramble and stray tick.
    set_geom(100, 130, 20, 0, 105, 0);
    run_frame("f_c1_hit", 1'b1);

    // Dino above the cactus.
    set_geom(100, 130, 20, 0, 105, 25);
    run_frame("f_jump", 1'b0);

    // Both cacti off-screen.
    set_geom(322, 130, 20, 20, 315, 0);
    run_frame("f_offscr", 1'b0);

    // Cactus2 wraps to x=77 and is hit.
    set_geom(400, 189, 0, 15, 70, 0);
    run_frame("f_c2_hit", 1'b0);

    // enable low: tick ignored.
    enable = 1'b0; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0; enable = 1'b1;
    check("enable low busy", 32'(busy), 32'd0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    m_lives = TB_LIVES; m_go = 0;
    check("clear lives", 32'(lives_left), 32'(TB_LIVES));

    // Collide until game over (bounded).
    set_geom(100, 130, 20, 0, 105, 0);
    for (int i = 0; i < 20 && m_go == 0; i++) run_frame("f_loop", 1'b0);
    check("go reached", 32'(game_over), 32'd1);
    check("go lives",   32'(lives_left), 32'd0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("go tick busy", 32'(busy), 32'd0);
    step();
    check("go tick busy2", 32'(busy), 32'd0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    m_lives = TB_LIVES; m_go = 0;
    check("clear2 lives", 32'(lives_left), 32'(TB_LIVES));
    check("clear2 go",    32'(game_over),  32'd0);

    // Clear aborts a check in progress.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();                                   // N+2
    clear = 1'b1;
    step();                                   // N+3
    clear = 1'b0;
    check("abort busy",  32'(busy),       32'd0);
    check("abort lives", 32'(lives_left), 32'(TB_LIVES));
    step();                                   // N+4
    check("abort done",  32'(done), 32'd0);
    check("abort hit",   32'(hit),  32'd0);

    // Reset mid-check of a colliding frame.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();                                   // N+2
    rst = 1'b1;
    step();                                   // N+3
    rst = 1'b0;
    m_lives = TB_LIVES; m_go = 0; m_grace = 0;
    check("rst busy",  32'(busy),       32'd0);
    check("rst lives", 32'(lives_left), 32'(TB_LIVES));
    step();                                   // N+4
    check("rst done",  32'(done), 32'd0);
    check("rst hit",   32'(hit),  32'd0);

    // Clear overrides a simultaneous tick.
    clear = 1'b1; frame_tick = 1'b1;
    step();
    clear = 1'b0; frame_tick = 1'b0;
    check("clr+tick busy", 32'(busy), 32'd0);
    step();
    check("clr+tick busy2", 32'(busy), 32'd0);

    // Grace sequence (hits on frames 1 and 4 when enabled, 1..3 otherwise).
    for (int i = 0; i < 4 && m_go == 0; i++) run_frame("f_grace", 1'b0);

    check("scoreboard drained", 32'(q_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_cactus_collide
`default_nettype wire
